// File: rtl/if_stage.sv
// Instruction fetch stage: holds one fetched instruction for decode, handles
// stalls, redirects (squash + refetch) and counts instructions handed to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_count
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic        if_valid_reg;
    logic [31:0] if_pc_reg;
    logic [31:0] if_instr_reg;
    logic [31:0] fetch_count_reg;
    logic        cap;
    logic        handoff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // BOOT is a single settling cycle; RUN persists until reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        cap     = (state_reg == RUN) && (!if_valid_reg || id_ready);
        handoff = if_valid_reg && id_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            if_valid_reg    <= 1'b0;
            if_pc_reg       <= 32'h0000_0000;
            if_instr_reg    <= NOP_INSTR;
            fetch_count_reg <= 32'h0000_0000;
        end else begin
            // A handoff still counts when a redirect lands on the same edge.
            if (handoff) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (redirect_valid) begin
                pc_reg       <= redirect_pc & 32'hFFFF_FFFC;
                if_valid_reg <= 1'b0;
                if_instr_reg <= NOP_INSTR;
            end else if (cap) begin
                if_valid_reg <= 1'b1;
                if_pc_reg    <= pc_reg;
                if_instr_reg <= imem_instr;
                pc_reg       <= pc_reg + 32'd4;
            end
        end
    end

    assign imem_addr   = pc_reg;
    assign if_valid    = if_valid_reg;
    assign if_pc       = if_pc_reg;
    assign if_instr    = if_instr_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: event-level reference model checked every cycle, plus
// directed boot/stall/redirect/wrap/reset scenarios with literal expectations.
module tb_if_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_count;

    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_instr;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_id_ready = 1'b1;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;
    logic [31:0] w_fetch_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_instr   = word_at(imem_addr);
    assign w_imem_instr = word_at(w_imem_addr);

    if_stage u_dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .id_ready(w_id_ready),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr),
        .fetch_count(w_fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a fetch cursor, a one-slot buffer and a consumed count.
    logic        m_live = 1'b0;
    int          m_boot_left;
    logic [31:0] m_cursor;
    logic        m_held;
    logic [31:0] m_held_pc;
    logic [31:0] m_held_word;
    logic [31:0] m_consumed;
    logic [31:0] handed[$];

    always @(posedge clk) begin
        if (rst) begin
            m_live      <= 1'b1;
            m_boot_left <= 1;
            m_cursor    <= 32'h0;
            m_held      <= 1'b0;
            m_held_pc   <= 32'h0;
            m_held_word <= NOP;
            m_consumed  <= 32'h0;
        end else if (m_live) begin
            if (m_held && id_ready) begin
                m_consumed <= m_consumed + 1;
                handed.push_back(if_pc);
            end
            m_boot_left <= 0;
            if (redirect_valid) begin
                m_cursor    <= {redirect_pc[31:2], 2'b00};
                m_held      <= 1'b0;
                m_held_word <= NOP;
            end else if (m_boot_left == 0 && (!m_held || id_ready)) begin
                m_held      <= 1'b1;
                m_held_pc   <= m_cursor;
                m_held_word <= word_at(m_cursor);
                m_cursor    <= m_cursor + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_imem_addr", imem_addr, m_cursor);
            chk("model_if_valid", {31'b0, if_valid}, {31'b0, m_held});
            chk("model_if_pc", if_pc, m_held_pc);
            chk("model_if_instr", if_instr, m_held_word);
            chk("model_fetch_count", fetch_count, m_consumed);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_handed[5];
        exp_handed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200};

        step(); step();
        chk("reset_if_valid", {31'b0, if_valid}, 32'h0);
        chk("reset_if_instr", if_instr, NOP);
        chk("reset_imem_addr", imem_addr, 32'h0);
        rst = 1'b0;
        step();
        chk("boot_no_capture", {31'b0, if_valid}, 32'h0);
        chk("wrap_boot_no_capture", {31'b0, w_if_valid}, 32'h0);
        step();
        chk("boot_first_valid", {31'b0, if_valid}, 32'h1);
        chk("boot_first_pc", if_pc, 32'h0);
        chk("wrap_pc0", w_if_pc, 32'hFFFF_FFF8);
        step();
        chk("boot_pc4", if_pc, 32'h4);
        chk("wrap_pc1", w_if_pc, 32'hFFFF_FFFC);
        step();
        chk("boot_pc8", if_pc, 32'h8);
        chk("boot_count2", fetch_count, 32'd2);
        chk("wrap_pc2", w_if_pc, 32'h0000_0000);

        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_if_pc", if_pc, 32'h8);
            chk("stall_if_instr", if_instr, 32'hDEAD_0008);
            chk("stall_imem_addr", imem_addr, 32'hC);
            if (i == 0) chk("wrap_pc3", w_if_pc, 32'h0000_0004);
        end
        id_ready = 1'b1;
        step();
        chk("unstall_if_pc", if_pc, 32'hC);
        chk("unstall_count3", fetch_count, 32'd3);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("redirect_squash", {31'b0, if_valid}, 32'h0);
        chk("redirect_nop", if_instr, NOP);
        chk("redirect_imem_addr", imem_addr, 32'h100);
        chk("redirect_counts_handoff", fetch_count, 32'd4);
        step();
        chk("redirect_target_valid", {31'b0, if_valid}, 32'h1);
        chk("redirect_target_pc", if_pc, 32'h100);

        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        chk("stall_redirect_squash", {31'b0, if_valid}, 32'h0);
        chk("stall_redirect_count", fetch_count, 32'd4);
        chk("misaligned_imem_addr", imem_addr, 32'h200);
        step();
        chk("misaligned_target_pc", if_pc, 32'h200);
        id_ready = 1'b1;
        step();
        chk("post_misaligned_count", fetch_count, 32'd5);

        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        step();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        chk("midrst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("midrst_count", fetch_count, 32'h0);
        chk("midrst_imem_addr", imem_addr, 32'h0);
        step();
        chk("midrst_boot", {31'b0, if_valid}, 32'h0);
        step();
        chk("midrst_refetch_pc", if_pc, 32'h0);
        chk("midrst_refetch_valid", {31'b0, if_valid}, 32'h1);

        chk("handed_len", handed.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < handed.size()) chk("handed_seq", handed[i], exp_handed[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
